pipeline_mul_add: RTL
=====================

Name: pipeline_mul_add

Overview:
- Inverse companion to the team's pipelined long divider: rebuilds a dividend from quotient, divisor and remainder, computing product = quotient * divisor + remainder.
- Fully pipelined shift-add: one multiplier bit per stage, one result per clock, valid bit travelling with the data.
- Used as an in-line self-checker behind the divider, and as a general signed-by-unsigned multiply-accumulate.

Parameters:
- dividend_width, 16, width of quotient and remainder (signed two's complement)
- divisor_width, 8, width of divisor (unsigned)
- product_width, dividend_width + divisor_width, derived; do not override

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  qualifies the operands this cycle
- quotient  in  dividend_width  signed multiplicand
- divisor  in  divisor_width  unsigned multiplier
- remainder  in  dividend_width  signed addend
- out_valid  out  1  product valid this cycle
- product  out  product_width  signed result
- fits  out  1  product representable in dividend_width signed bits (see Optional Feature)

Behaviour:
- Reset, sampled on a clock edge with reset=1:
  - clears every pipeline valid bit; out_valid=0, product=0, fits=0 on the following cycle.
  - Stage data registers need no reset.
- Reset mid-operation: all in-flight operations are dropped and never appear at the output. in_valid on the edge where reset=1 is ignored.
- Stage 0, edge k: registers the operands.
  - quotient sign-extended to product_width as M
  - remainder sign-extended to product_width as accumulator A0
  - divisor as D
  - in_valid as v0
- Stage i (1..divisor_width), edge k+i:
  - A_i = A_(i-1) + (D[i-1] ? M << (i-1) : 0), modulo 2^product_width.
  - M, D and valid pass through unchanged.
- Output register, edge k+divisor_width+1:
  - out_valid <= v_last.
  - product and fits load only when v_last=1; otherwise they hold their last value.
- Latency: operands sampled at edge k appear with out_valid=1 after edge k+divisor_width+1 (9 edges at defaults). Throughput 1/clock, no stall, no backpressure.
- Arithmetic: exact; the result can never overflow product_width.
  - Extremes: -2^(dw-1)*(2^vw-1) - 2^(dw-1) = -2^(product_width-1), and the maximum positive value is below 2^(product_width-1).
  - No saturation, no wrap handling required.
- Edge operands:
  - divisor=0 gives product = remainder sign-extended.
  - quotient = most-negative value is handled with no special case.
- Back-to-back and gapped in_valid streams keep order and spacing exactly.
- Data registers of invalid slots may toggle freely; only out_valid qualifies product.

Optional Feature:
- Macro MUL_ADD_FIT_CHECK_EN.
- Defined:
  - fits is registered alongside product.
  - fits = 1 iff product[product_width-1:dividend_width-1] is all 0s or all 1s, i.e. the rebuilt dividend fits the divider's input width.
- Undefined:
  - fits is tied to 0.
  - No compare logic is built; the port remains for a stable interface.

Decomposition:
- Package divider_pkg:
  - default widths DIVIDEND_WIDTH=16 and DIVISOR_WIDTH=8
  - a product-width helper function
  - shared with the divider
- Sub-module mul_add_stage: one shift-add stage.
  - Parameterised by stage index and product_width.
  - Registers A, M, D and valid.
  - Instantiated divisor_width times in a generate loop.

Test Plan (dividend_width=8, divisor_width=4, product_width=12):
- quotient=-8 (8'hF8), divisor=2, remainder=-1, in_valid=1 for one cycle -> 5 edges later out_valid=1 for exactly one cycle, product=12'hFEF (-17).
- Stream 4 consecutive operand sets (33*3+0, 33*3+1, 21*4+1, 1*15+0) -> out_valid high 4 consecutive cycles; products 99, 100, 85, 15 in order.
- divisor=0, quotient=127, remainder=-128 -> product=12'hF80. With MUL_ADD_FIT_CHECK_EN: fits=1.
- quotient=-128, divisor=15, remainder=-128 -> product=12'h800 (-2048). fits=0 with the macro, 0 without.
- Assert reset two cycles after issuing 3 valid operands -> no out_valid for those; product=0; the next operand after reset releases produces a correct result at the normal latency.
- Gapped stream (valid, idle, idle, valid) -> outputs keep the same gaps; product holds the first result during idle cycles.

Source files
------------

// File: rtl/divider_pkg.sv
// Widths shared by the pipelined long divider and its multiply-add companion,
// plus the helper that derives the full product/dividend-rebuild width.
package divider_pkg;

  localparam int DIVIDEND_WIDTH = 16;
  localparam int DIVISOR_WIDTH  = 8;

  function automatic int product_width_f(input int dividend_w, input int divisor_w);
    return dividend_w + divisor_w;
  endfunction

endpackage

// File: rtl/mul_add_stage.sv
// One shift-add stage: conditionally adds the multiplicand, shifted by the
// stage's bit weight, into the running accumulator; operands ride along.
module mul_add_stage
  import divider_pkg::*;
#(
  parameter int STAGE_IDX = 1,
  parameter int DIVISOR_W = DIVISOR_WIDTH,
  parameter int PRODUCT_W = product_width_f(DIVIDEND_WIDTH, DIVISOR_WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic [PRODUCT_W-1:0] acc_i,
  input  logic [PRODUCT_W-1:0] mcand_i,
  input  logic [DIVISOR_W-1:0] mplier_i,
  output logic                 valid_o,
  output logic [PRODUCT_W-1:0] acc_o,
  output logic [PRODUCT_W-1:0] mcand_o,
  output logic [DIVISOR_W-1:0] mplier_o
);

  logic                 valid_q;
  logic [PRODUCT_W-1:0] acc_d;
  logic [PRODUCT_W-1:0] acc_q;
  logic [PRODUCT_W-1:0] mcand_q;
  logic [DIVISOR_W-1:0] mplier_q;

  always_comb begin
    acc_d = acc_i;
    if (mplier_i[STAGE_IDX-1]) begin
      acc_d = acc_i + (mcand_i << (STAGE_IDX - 1));
    end
  end

  // Only the valid bit needs reset; data in empty slots is don't-care.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
    end
    acc_q    <= acc_d;
    mcand_q  <= mcand_i;
    mplier_q <= mplier_i;
  end

  assign valid_o  = valid_q;
  assign acc_o    = acc_q;
  assign mcand_o  = mcand_q;
  assign mplier_o = mplier_q;

endmodule

// File: rtl/pipeline_mul_add.sv
// Pipelined product = quotient * divisor + remainder, one divisor bit per stage.
// Optional MUL_ADD_FIT_CHECK_EN builds the registered "fits in dividend width" flag.
module pipeline_mul_add
  import divider_pkg::*;
#(
  parameter  int dividend_width = DIVIDEND_WIDTH,
  parameter  int divisor_width  = DIVISOR_WIDTH,
  localparam int product_width  = product_width_f(dividend_width, divisor_width)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [dividend_width-1:0] quotient,
  input  logic [divisor_width-1:0]  divisor,
  input  logic [dividend_width-1:0] remainder,
  output logic                      out_valid,
  output logic [product_width-1:0]  product,
  output logic                      fits
);

  logic [divisor_width:0]     valid_pipe;
  logic [product_width-1:0]   acc_pipe    [0:divisor_width];
  logic [product_width-1:0]   mcand_pipe  [0:divisor_width];
  logic [divisor_width-1:0]   mplier_pipe [0:divisor_width];

  logic                       v0_q;
  logic [product_width-1:0]   acc0_q;
  logic [product_width-1:0]   mcand0_q;
  logic [divisor_width-1:0]   mplier0_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      v0_q <= 1'b0;
    end else begin
      v0_q <= in_valid;
    end
    mcand0_q  <= {{divisor_width{quotient[dividend_width-1]}}, quotient};
    acc0_q    <= {{divisor_width{remainder[dividend_width-1]}}, remainder};
    mplier0_q <= divisor;
  end

  assign valid_pipe[0]  = v0_q;
  assign acc_pipe[0]    = acc0_q;
  assign mcand_pipe[0]  = mcand0_q;
  assign mplier_pipe[0] = mplier0_q;

  for (genvar i = 1; i <= divisor_width; i++) begin : g_stage
    mul_add_stage #(
      .STAGE_IDX (i),
      .DIVISOR_W (divisor_width),
      .PRODUCT_W (product_width)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .valid_i  (valid_pipe[i-1]),
      .acc_i    (acc_pipe[i-1]),
      .mcand_i  (mcand_pipe[i-1]),
      .mplier_i (mplier_pipe[i-1]),
      .valid_o  (valid_pipe[i]),
      .acc_o    (acc_pipe[i]),
      .mcand_o  (mcand_pipe[i]),
      .mplier_o (mplier_pipe[i])
    );
  end

  // The last stage's pass-through operands have no consumer.
  logic unused_tail;
  assign unused_tail = ^{mcand_pipe[divisor_width], mplier_pipe[divisor_width]};

  logic                     valid_last;
  logic [product_width-1:0] acc_last;
  assign valid_last = valid_pipe[divisor_width];
  assign acc_last   = acc_pipe[divisor_width];

  logic                     out_valid_q;
  logic [product_width-1:0] product_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else begin
      out_valid_q <= valid_last;
      if (valid_last) begin
        product_q <= acc_last;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;

`ifdef MUL_ADD_FIT_CHECK_EN
  // Fits when everything from the dividend sign bit upward is pure sign extension.
  logic [divisor_width:0] upper_bits;
  logic                   fits_d;
  logic                   fits_q;

  assign upper_bits = acc_last[product_width-1:dividend_width-1];
  assign fits_d     = (&upper_bits) | ~(|upper_bits);

  always_ff @(posedge clock) begin
    if (reset) begin
      fits_q <= 1'b0;
    end else if (valid_last) begin
      fits_q <= fits_d;
    end
  end

  assign fits = fits_q;
`else
  assign fits = 1'b0;
`endif

endmodule
